ifu_fetch_q: RTL



---
 rtl/ifu_fetch_q_pkg.sv | 22 ++
 rtl/ifu_fetch_q_fifo.sv | 73 +++++++
 rtl/ifu_fetch_q.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ifu_fetch_q_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states and the
// layout of a fetch queue entry.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned DEF_XLEN   = 64;
    localparam int unsigned DEF_ILEN   = 32;

    // Entry layout for the default 64-bit configuration; the top builds the
    // same {pc, inst} shape from its own XLEN/ILEN.
    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_q_fifo.sv
// Registered circular fetch queue. Flush overrides push and pop; a
// simultaneous push and pop leaves the occupancy unchanged.
module fetch_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_s;
    logic             pop_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign pop_s     = pop & ~empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_s    = push & (~full | pop_s);

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            rd_ptr_r <= AW'(0);
            wr_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (!flush && push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_fetch_q.sv
// Instruction fetch unit: owns the fetch PC, keeps one request in flight to
// instruction memory and queues returned instructions for decode.
module ifu_fetch_q
    import ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter int unsigned     FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redir_valid,
    input  logic            redir_clr_lsb,
    input  logic [XLEN-1:0] redir_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_dnpc
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] fetch_pc_nxt_s;
    logic [XLEN-1:0] req_pc_r;
    logic [XLEN-1:0] redir_pc_s;
    logic            hs_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [CW-1:0]   fifo_count_s;
    entry_t          push_entry_s;
    entry_t          head_s;

    // Only request when the queue can still hold the response; with a single
    // request in flight this guarantees the push never overflows.
    assign imem_req_valid = rst_n & (state_r == S_REQ) & (fifo_count_s < CW'(FQ_DEPTH));
    assign imem_req_addr  = fetch_pc_r;
    assign hs_s           = imem_req_valid & imem_req_ready;
    assign redir_pc_s     = redir_clr_lsb ? {redir_target[XLEN-1:1], 1'b0} : redir_target;
    assign pop_s          = out_ready & ~redir_valid;
    assign push_entry_s   = '{pc: req_pc_r, inst: imem_rsp_data};

    // Next-state, next-PC and enqueue decision; a redirect overrides everything
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        push_s         = 1'b0;
        if (redir_valid) begin
            fetch_pc_nxt_s = redir_pc_s;
            case (state_r)
                S_REQ:          state_nxt_s = hs_s ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_nxt_s = imem_rsp_valid ? S_REQ : S_DROP;
                default:        state_nxt_s = S_REQ;
            endcase
        end else begin
            case (state_r)
                S_REQ: begin
                    if (hs_s) begin
                        state_nxt_s    = S_WAIT;
                        fetch_pc_nxt_s = fetch_pc_r + XLEN'(INST_BYTES);
                    end else begin
                        state_nxt_s    = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        push_s      = ~full_s;
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_WAIT;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid) begin
                        state_nxt_s = S_REQ;
                    end else begin
                        state_nxt_s = S_DROP;
                    end
                end
                default: state_nxt_s = S_REQ;
            endcase
        end
    end

    // FSM state, fetch PC and the PC of the request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_REQ;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            if (hs_s) begin
                req_pc_r <= fetch_pc_r;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redir_valid),
        .push_data (push_entry_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_count_s),
        .head_data (head_s)
    );

    assign out_valid = ~empty_s;
    assign out_pc    = head_s.pc;
    assign out_inst  = head_s.inst;
    assign out_dnpc  = head_s.pc + XLEN'(INST_BYTES);

endmodule
